// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment scan driver: FSM encoding and
// segment patterns in {g,f,e,d,c,b,a} order, logical (active-high) polarity.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-side bundle: BCD input and enable toward the driver, pin-level
// segment/digit outputs and the frame strobe back out.
interface bcd_7seg_scan_driver_if #(
    parameter int NUM_DIGITS = 2
);
    logic                      en;
    logic [NUM_DIGITS*4-1:0]   bcd_in;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic                      frame_done;

    modport master (
        output en, bcd_in,
        input  seg_out, dp_out, digit_sel, frame_done
    );

    modport slave (
        input  en, bcd_in,
        output seg_out, dp_out, digit_sel, frame_done
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to gfedcba pattern; codes 10..15 show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: blank gap, then drive each digit in turn
// from a shadow copy of bcd_in that is refreshed only at frame boundaries.
module bcd_7seg_scan_driver
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int DRIVE_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_7seg_scan_driver_if.slave  bus
);
    localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW   = NUM_DIGITS * 4;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Output flops hold pin-level values, so "off" depends on polarity.
    localparam logic [6:0]            SEG_PIN_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_PIN_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_PIN_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         shadow_q, shadow_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic [3:0]            cur_bcd;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [6:0]            seg_logic;
    logic [NUM_DIGITS-1:0] dig_logic;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shadow_d = bus.bcd_in;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            shadow_d     = bus.bcd_in;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign cur_bcd = shadow_d[{idx_d, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (shadow_d[i*4 +: 4] == 4'd0);
            lz_blank[i] = (LZ_BLANK != 0) && (i > 0) && zero_run;
        end
    end

    // Outputs are derived from the next state so the registered pins line up
    // with the state they belong to.
    always_comb begin
        seg_logic = SEG_OFF;
        dig_logic = '0;
        if (state_d == DRIVE) begin
            dig_logic = NUM_DIGITS'(1) << idx_d;
            seg_logic = lz_blank[idx_d] ? SEG_OFF : cur_seg;
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_logic : seg_logic;
        dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_logic : dig_logic;
        dp_d  = DP_PIN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_PIN_OFF;
            dp_q         <= DP_PIN_OFF;
            dig_q        <= DIG_PIN_OFF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.digit_sel  = dig_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: two instances (leading-zero blanking on/off)
// compared every cycle against a frame-position reference model.
module tb_bcd_7seg_scan_driver;
    localparam int ND    = 2;
    localparam int DC    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = BC + DC;
    localparam int FRAME = ND * SLOT;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] bcd   = 8'h00;

    always #5 clk = ~clk;

    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_lz ();
    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_nz ();

    assign bus_lz.en     = en;
    assign bus_lz.bcd_in = bcd;
    assign bus_nz.en     = en;
    assign bus_nz.bcd_in = bcd;

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(ND), .DRIVE_CYCLES(DC), .BLANK_CYCLES(BC),
        .LZ_BLANK(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_lz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lz.slave)
    );

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(ND), .DRIVE_CYCLES(DC), .BLANK_CYCLES(BC),
        .LZ_BLANK(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nz.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Segment patterns, gfedcba, indexed by the 4-bit code.
    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

    // Model: m_pos is the cycle offset inside the current frame.
    bit         m_act   = 1'b0;
    int         m_pos   = 0;
    logic [7:0] m_shadow = 8'h00;
    bit         m_wrap  = 1'b0;

    function automatic logic [1:0] exp_sel();
        if (!m_act || (m_pos % SLOT) < BC) return 2'b00;
        return 2'(1 << (m_pos / SLOT));
    endfunction

    function automatic logic [6:0] exp_seg(input bit lz);
        int slot;
        if (!m_act || (m_pos % SLOT) < BC) return 7'b0;
        slot = m_pos / SLOT;
        if (lz && slot > 0 && (m_shadow >> (4 * slot)) == 8'h00) return 7'b0;
        return seg_tab[(m_shadow >> (4 * slot)) & 8'h0F];
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!rst_n || !en) begin
            m_act  = 1'b0;
            m_wrap = 1'b0;
        end else if (!m_act) begin
            m_act    = 1'b1;
            m_pos    = 0;
            m_shadow = bcd;
            m_wrap   = 1'b0;
        end else begin
            m_pos++;
            m_wrap = 1'b0;
            if (m_pos == FRAME) begin
                m_pos    = 0;
                m_shadow = bcd;
                m_wrap   = 1'b1;
            end
        end
        @(negedge clk);
        chk("seg_lz",   32'(bus_lz.seg_out),    32'(exp_seg(1'b1)));
        chk("seg_nolz", 32'(bus_nz.seg_out),    32'(exp_seg(1'b0)));
        chk("sel",      32'(bus_lz.digit_sel),  32'(exp_sel()));
        chk("sel_nolz", 32'(bus_nz.digit_sel),  32'(exp_sel()));
        chk("frame",    32'(bus_lz.frame_done), 32'(m_act && m_wrap));
        chk("dp",       32'(bus_lz.dp_out),     32'd0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        // Reset held with enable asserted: everything dark.
        rst_n = 1'b0;
        en    = 1'b1;
        bcd   = 8'h42;
        run(3);

        @(negedge clk);
        rst_n = 1'b1;
        run(3 * FRAME + 3);

        // Asynchronous clear while a digit is being driven.
        for (int k = 0; k < 2 * FRAME && exp_sel() == 2'b00; k++) cycle();
        chk("pre_rst_sel", 32'(bus_lz.digit_sel != 2'b00), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_seg",   32'(bus_lz.seg_out),    32'd0);
        chk("async_sel",   32'(bus_lz.digit_sel),  32'd0);
        chk("async_frame", 32'(bus_lz.frame_done), 32'd0);
        run(2);
        rst_n = 1'b1;
        run(FRAME + 2);

        // Directed patterns: leading zeros, all-zero, invalid code.
        bcd = 8'h07; run(2 * FRAME + 1);
        bcd = 8'h00; run(2 * FRAME + 1);
        bcd = 8'hC3; run(2 * FRAME + 1);

        // Input changes during digit 0 drive must not reach digit 1 this frame.
        bcd = 8'h42;
        for (int k = 0; k < 3 * FRAME && !(m_act && m_pos == BC + 1); k++) cycle();
        bcd = 8'h99;
        run(2 * FRAME + 1);

        // Single-cycle enable drop mid-drive, then restart.
        for (int k = 0; k < 2 * FRAME && exp_sel() == 2'b00; k++) cycle();
        en = 1'b0; cycle();
        en = 1'b1; run(2 * FRAME + 2);

        // Randomised traffic with occasional enable drops and invalid codes.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) bcd = 8'($urandom);
            en = ($urandom_range(0, 39) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
